// File: rtl/agex_mul_seq_pkg.sv
// Shared types and defaults for the AGEX shift-add multiply sequencer.
package agex_mul_seq_pkg;

    // Sequencer state encoding (2 bits, IDLE must stay 0 for reset).
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mulseq_state_e;

    localparam int MULSEQ_DBITS_DEF     = 32;
    localparam int MULSEQ_BPC_DEF       = 1;
    localparam int MULSEQ_REGNOBITS_DEF = 5;

    // Width of the bundle handed back to the AGEX latch: done, result, rd, inst_count.
    function automatic int mulseq_to_agex_width(input int dbits, input int regnobits);
        return 1 + dbits + regnobits + dbits;
    endfunction

endpackage

// File: rtl/agex_mul_seq_if.sv
// Request/result bundle between AGEX (master) and the multiply sequencer (slave).
interface agex_mul_seq_if #(
    parameter int DBITS     = 32,
    parameter int REGNOBITS = 5
);
    logic                 start;
    logic                 flush;
    logic [DBITS-1:0]     op_a;
    logic [DBITS-1:0]     op_b;
    logic [REGNOBITS-1:0] rd_in;
    logic [DBITS-1:0]     cnt_in;
    logic                 stall;
    logic                 busy;
    logic                 done;
    logic [DBITS-1:0]     result;
    logic [REGNOBITS-1:0] rd_out;
    logic [DBITS-1:0]     cnt_out;

    modport master (
        output start, flush, op_a, op_b, rd_in, cnt_in,
        input  stall, busy, done, result, rd_out, cnt_out
    );

    modport slave (
        input  start, flush, op_a, op_b, rd_in, cnt_in,
        output stall, busy, done, result, rd_out, cnt_out
    );
endinterface

// File: rtl/agex_mul_seq_step.sv
// One RUN iteration of the datapath: acc + mcand * mplier_bits as BPC shifted-add terms.
module agex_mul_seq_step #(
    parameter int DBITS = 32,
    parameter int BPC   = 1
) (
    input  logic [DBITS-1:0] acc,
    input  logic [DBITS-1:0] mcand,
    input  logic [BPC-1:0]   mplier_bits,
    output logic [DBITS-1:0] acc_next
);

    // Sum the partial products selected by the retired multiplier bits, truncated to DBITS.
    always_comb begin
        acc_next = acc;
        for (int i = 0; i < BPC; i++) begin
            if (mplier_bits[i]) begin
                acc_next = acc_next + (mcand << i);
            end
        end
    end

endmodule

// File: rtl/agex_mul_seq.sv
// Iterative shift-add multiplier for MUL_I in AGEX: stalls the front end while running,
// returns the low DBITS of the product with the captured rd and inst_count.
module agex_mul_seq
    import agex_mul_seq_pkg::*;
#(
    parameter int DBITS     = MULSEQ_DBITS_DEF,
    parameter int BPC       = MULSEQ_BPC_DEF,
    parameter int REGNOBITS = MULSEQ_REGNOBITS_DEF
) (
    input logic          clk,
    input logic          reset,
    agex_mul_seq_if.slave bus
);

    localparam int ITERS = DBITS / BPC;
    localparam int IW    = $clog2(ITERS + 1);
    localparam logic [IW-1:0] ITER_MAX = IW'(ITERS);

    mulseq_state_e        state_q,  state_d;
    logic [DBITS-1:0]     acc_q,    acc_d;
    logic [DBITS-1:0]     mcand_q,  mcand_d;
    logic [DBITS-1:0]     mplier_q, mplier_d;
    logic [IW-1:0]        iter_q,   iter_d;
    logic [REGNOBITS-1:0] rd_q,     rd_d;
    logic [DBITS-1:0]     tag_q,    tag_d;
    logic                 busy_q,   busy_d;
    logic                 done_q,   done_d;

    logic [DBITS-1:0]     acc_step;
    logic [DBITS-1:0]     mcand_shift;
    logic [DBITS-1:0]     mplier_shift;
    logic [IW-1:0]        iter_inc;
    logic                 accept;

    agex_mul_seq_step #(
        .DBITS (DBITS),
        .BPC   (BPC)
    ) u_step (
        .acc         (acc_q),
        .mcand       (mcand_q),
        .mplier_bits (mplier_q[BPC-1:0]),
        .acc_next    (acc_step)
    );

    // A start in RUN is ignored; a flush always drops the request.
    assign accept       = bus.start & ~bus.flush & (state_q != ST_RUN);
    assign mcand_shift  = mcand_q << BPC;
    assign mplier_shift = mplier_q >> BPC;
    assign iter_inc     = iter_q + IW'(1);

    // Next-state and datapath update; flush beats everything, early exit on empty multiplier.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        iter_d   = iter_q;
        rd_d     = rd_q;
        tag_d    = tag_q;
        if (bus.flush) begin
            state_d = ST_IDLE;
        end else if (accept) begin
            acc_d    = '0;
            mcand_d  = bus.op_a;
            mplier_d = bus.op_b;
            iter_d   = '0;
            rd_d     = bus.rd_in;
            tag_d    = bus.cnt_in;
            state_d  = (bus.op_b == '0) ? ST_DONE : ST_RUN;
        end else if (state_q == ST_RUN) begin
            acc_d    = acc_step;
            mcand_d  = mcand_shift;
            mplier_d = mplier_shift;
            iter_d   = iter_inc;
            if ((mplier_shift == '0) || (iter_inc == ITER_MAX)) begin
                state_d = ST_DONE;
            end
        end else begin
            state_d = ST_IDLE;
        end
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State, datapath and status flops; async active-low reset returns everything to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            iter_q   <= '0;
            rd_q     <= '0;
            tag_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            iter_q   <= iter_d;
            rd_q     <= rd_d;
            tag_q    <= tag_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Stall covers the request cycle and every RUN cycle; a flush releases the front end at once.
    assign bus.stall   = ~bus.flush & ((state_q == ST_RUN) | (bus.start & (state_q != ST_RUN)));
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.result  = acc_q;
    assign bus.rd_out  = rd_q;
    assign bus.cnt_out = tag_q;

endmodule

// File: tb/tb_agex_mul_seq.sv
// Directed bench for agex_mul_seq: BPC=1 and BPC=4 instances driven with the same vectors.
module tb_agex_mul_seq;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    agex_mul_seq_if #(.DBITS(32), .REGNOBITS(5)) m1 ();
    agex_mul_seq_if #(.DBITS(32), .REGNOBITS(5)) m4 ();

    agex_mul_seq #(.DBITS(32), .BPC(1), .REGNOBITS(5)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (m1)
    );

    agex_mul_seq #(.DBITS(32), .BPC(4), .REGNOBITS(5)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (m4)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] cnt;
        logic [31:0] res;
        int          n1;
        int          n4;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        m1.start = 1'b0; m1.flush = 1'b0; m1.op_a = '0; m1.op_b = '0; m1.rd_in = '0; m1.cnt_in = '0;
        m4.start = 1'b0; m4.flush = 1'b0; m4.op_a = '0; m4.op_b = '0; m4.rd_in = '0; m4.cnt_in = '0;
    endtask

    task automatic drive1(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd, input logic [31:0] cnt);
        m1.start = 1'b1; m1.op_a = a; m1.op_b = b; m1.rd_in = rd; m1.cnt_in = cnt;
    endtask

    // Called at posedge+1; returns edges elapsed until done is seen, or -1 if the bound expires.
    task automatic wait_done1(output int n);
        n = -1;
        for (int k = 0; k < 60; k++) begin
            if (m1.done) begin
                n = k;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        int n1, n4, st1, st4;
        logic [31:0] r1, r4, c1;
        logic [4:0]  d1;
        n1 = -1; n4 = -1; st1 = 0; st4 = 0;
        r1 = '0; r4 = '0; c1 = '0; d1 = '0;
        @(posedge clk); #1;
        drive1(v.a, v.b, v.rd, v.cnt);
        m4.start = 1'b1; m4.op_a = v.a; m4.op_b = v.b; m4.rd_in = v.rd; m4.cnt_in = v.cnt;
        #1;
        st1 += int'(m1.stall);
        st4 += int'(m4.stall);
        @(posedge clk); #1;
        m1.start = 1'b0;
        m4.start = 1'b0;
        for (int k = 0; k < 40 && (n1 < 0 || n4 < 0); k++) begin
            if (n1 < 0) begin
                if (m1.done) begin
                    n1 = k; r1 = m1.result; d1 = m1.rd_out; c1 = m1.cnt_out;
                end else begin
                    st1 += int'(m1.stall);
                end
            end
            if (n4 < 0) begin
                if (m4.done) begin
                    n4 = k; r4 = m4.result;
                end else begin
                    st4 += int'(m4.stall);
                end
            end
            if (n1 < 0 || n4 < 0) begin
                @(posedge clk); #1;
            end
        end
        check($sformatf("v%0d_latency_bpc1", idx), 32'(n1), 32'(v.n1));
        check($sformatf("v%0d_latency_bpc4", idx), 32'(n4), 32'(v.n4));
        check($sformatf("v%0d_result_bpc1", idx), r1, v.res);
        check($sformatf("v%0d_result_bpc4", idx), r4, v.res);
        check($sformatf("v%0d_rd_out", idx), {27'd0, d1}, {27'd0, v.rd});
        check($sformatf("v%0d_cnt_out", idx), c1, v.cnt);
        check($sformatf("v%0d_stall_cycles_bpc1", idx), 32'(st1), 32'(v.n1 + 1));
        check($sformatf("v%0d_stall_cycles_bpc4", idx), 32'(st4), 32'(v.n4 + 1));
        @(posedge clk); #1;
        @(posedge clk); #1;
        check($sformatf("v%0d_idle_busy", idx), {31'd0, m1.busy}, 32'd0);
        check($sformatf("v%0d_result_hold", idx), m1.result, v.res);
        check($sformatf("v%0d_rd_hold", idx), {27'd0, m1.rd_out}, {27'd0, v.rd});
    endtask

    initial begin
        int n;
        idle_inputs();
        reset = 1'b0;

        vecs[0] = '{a: 32'd7,         b: 32'd5,          rd: 5'd3,  cnt: 32'h100, res: 32'd35,        n1: 3,  n4: 1};
        vecs[1] = '{a: 32'hDEADBEEF,  b: 32'd0,          rd: 5'd4,  cnt: 32'h101, res: 32'd0,         n1: 0,  n4: 0};
        vecs[2] = '{a: 32'hFFFFFFFF,  b: 32'hFFFFFFFF,   rd: 5'd31, cnt: 32'h102, res: 32'h00000001,  n1: 32, n4: 8};
        vecs[3] = '{a: 32'hFFFFFFFE,  b: 32'd3,          rd: 5'd5,  cnt: 32'h103, res: 32'hFFFFFFFA,  n1: 2,  n4: 1};
        vecs[4] = '{a: 32'd3,         b: 32'd4,          rd: 5'd6,  cnt: 32'h104, res: 32'd12,        n1: 3,  n4: 1};
        vecs[5] = '{a: 32'h12345678,  b: 32'h00000100,   rd: 5'd7,  cnt: 32'h105, res: 32'h34567800,  n1: 9,  n4: 3};
        vecs[6] = '{a: 32'h00000010,  b: 32'h80000000,   rd: 5'd8,  cnt: 32'h106, res: 32'h00000000,  n1: 32, n4: 8};
        vecs[7] = '{a: 32'd1,         b: 32'h000000F0,   rd: 5'd9,  cnt: 32'h107, res: 32'h000000F0,  n1: 8,  n4: 2};
        vecs[8] = '{a: 32'h0000FFFF,  b: 32'h00010001,   rd: 5'd10, cnt: 32'h108, res: 32'hFFFFFFFF,  n1: 17, n4: 5};

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",    {31'd0, m1.busy},  32'd0);
        check("rst_stall",   {31'd0, m1.stall}, 32'd0);
        check("rst_done",    {31'd0, m1.done},  32'd0);
        check("rst_result",  m1.result,         32'd0);
        check("rst_rd_out",  {27'd0, m1.rd_out}, 32'd0);
        check("rst_cnt_out", m1.cnt_out,        32'd0);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            apply_vec(vecs[i], i);
        end

        // Flush at RUN cycle 10 with a simultaneous start: both the run and the request are dropped.
        @(posedge clk); #1;
        drive1(32'd1, 32'h80000000, 5'd11, 32'h200);
        @(posedge clk); #1;
        m1.start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("flush_pre_busy", {31'd0, m1.busy}, 32'd1);
        m1.flush = 1'b1;
        drive1(32'd2, 32'd5, 5'd12, 32'h201);
        @(posedge clk); #1;
        m1.flush = 1'b0;
        m1.start = 1'b0;
        check("flush_busy",  {31'd0, m1.busy},  32'd0);
        check("flush_stall", {31'd0, m1.stall}, 32'd0);
        check("flush_done",  {31'd0, m1.done},  32'd0);
        wait_done1(n);
        check("flush_no_done", 32'(n), 32'hFFFFFFFF);

        // Back-to-back: new start issued in the DONE cycle of the previous multiply.
        drive1(32'd5, 32'd2, 5'd1, 32'h0A);
        @(posedge clk); #1;
        m1.start = 1'b0;
        wait_done1(n);
        check("b2b_first_latency", 32'(n), 32'd2);
        check("b2b_first_result",  m1.result, 32'd10);
        drive1(32'd3, 32'd4, 5'd7, 32'h55);
        #1;
        check("b2b_stall_in_done", {31'd0, m1.stall}, 32'd1);
        @(posedge clk); #1;
        m1.start = 1'b0;
        wait_done1(n);
        check("b2b_latency", 32'(n), 32'd3);
        check("b2b_result",  m1.result, 32'd12);
        check("b2b_rd_out",  {27'd0, m1.rd_out}, 32'd7);
        check("b2b_cnt_out", m1.cnt_out, 32'h55);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a run.
        drive1(32'd9, 32'h80000003, 5'd9, 32'h77);
        @(posedge clk); #1;
        m1.start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("arst_pre_busy",   {31'd0, m1.busy}, 32'd1);
        check("arst_pre_result", m1.result, 32'd27);
        #2;
        reset = 1'b0;
        #1;
        check("arst_busy",    {31'd0, m1.busy},  32'd0);
        check("arst_stall",   {31'd0, m1.stall}, 32'd0);
        check("arst_done",    {31'd0, m1.done},  32'd0);
        check("arst_result",  m1.result,         32'd0);
        check("arst_rd_out",  {27'd0, m1.rd_out}, 32'd0);
        check("arst_cnt_out", m1.cnt_out,        32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("arst_idle_busy", {31'd0, m1.busy}, 32'd0);
        wait_done1(n);
        check("arst_no_done", 32'(n), 32'hFFFFFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
